// File: rtl/decode_stage.sv
// Decode stage: register file, RV-style field/immediate extraction, busy-bit
// scoreboard with optional writeback bypass, and a one-deep output register.
module decode_stage #(
   parameter int XLEN      = 32,
   parameter int REG_COUNT = 32,
   parameter int BYPASS_EN = 1,
   localparam int AW       = $clog2(REG_COUNT)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [AW-1:0]   out_rd,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [XLEN-1:0] out_imm,
   output logic            out_illegal
);

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;

   logic [XLEN-1:0]      regs [REG_COUNT];
   logic [REG_COUNT-1:0] busy;
   logic [REG_COUNT-1:0] busy_next;

   logic [6:0]      opcode;
   logic            use_rs1, use_rs2, use_rd, use_f3, use_f7, illegal;
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm_ext;
   logic [AW-1:0]   dec_rd, dec_rs1, dec_rs2;
   logic            byp1, byp2, haz1, haz2, haz_rd, hazard, accept;
   logic [XLEN-1:0] rs1_data, rs2_data;

   assign opcode = in_instr[6:0];

   // Classify the opcode: which register fields and funct fields are live, and the immediate format.
   always_comb begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      use_f3  = 1'b0;
      use_f7  = 1'b0;
      illegal = 1'b0;
      imm32   = '0;
      case (opcode)
         OP_R: begin
            use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1; use_f7 = 1'b1;
         end
         OP_IMM, OP_LOAD, OP_JALR: begin
            use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1;
            imm32  = {{20{in_instr[31]}}, in_instr[31:20]};
         end
         OP_STORE: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
            imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         end
         OP_BRANCH: begin
            use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
            imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
         end
         OP_JAL: begin
            use_rd = 1'b1;
            imm32  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            use_rd = 1'b1;
            imm32  = {in_instr[31:12], 12'b0};
         end
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      imm_ext       = {XLEN{imm32[31]}};
      imm_ext[31:0] = imm32;
   end

   assign dec_rd  = use_rd  ? in_instr[7  +: AW] : '0;
   assign dec_rs1 = use_rs1 ? in_instr[15 +: AW] : '0;
   assign dec_rs2 = use_rs2 ? in_instr[20 +: AW] : '0;

   // A source matching this cycle's writeback is satisfied by the bypass instead of stalling.
   assign byp1 = (BYPASS_EN != 0) && wb_en && (wb_rd == dec_rs1) && (dec_rs1 != '0);
   assign byp2 = (BYPASS_EN != 0) && wb_en && (wb_rd == dec_rs2) && (dec_rs2 != '0);

   assign haz1   = (dec_rs1 != '0) && (busy[dec_rs1] || (out_valid && out_rd == dec_rs1)) && !byp1;
   assign haz2   = (dec_rs2 != '0) && (busy[dec_rs2] || (out_valid && out_rd == dec_rs2)) && !byp2;
   assign haz_rd = (dec_rd  != '0) && (busy[dec_rd]  || (out_valid && out_rd == dec_rd));
   assign hazard = haz1 || haz2 || haz_rd;

   assign rs1_data = (dec_rs1 == '0) ? '0 : (byp1 ? wb_data : regs[dec_rs1]);
   assign rs2_data = (dec_rs2 == '0) ? '0 : (byp2 ? wb_data : regs[dec_rs2]);

   assign in_ready = reset && (!out_valid || out_ready) && !hazard && !flush;
   assign accept   = in_valid && in_ready;

   // Register file; x0 is never written so it always reads zero.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (wb_en && wb_rd != '0) begin
         regs[wb_rd] <= wb_data;
      end
   end

   // Scoreboard update: the clear is applied first so that a simultaneous set wins.
   always_comb begin
      busy_next = busy;
      if (wb_en) busy_next[wb_rd] = 1'b0;
      if (out_valid && out_ready && out_rd != '0) busy_next[out_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset || flush) busy <= '0;
      else                 busy <= busy_next;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid    <= 1'b0;
         out_pc       <= '0;
         out_opcode   <= '0;
         out_funct3   <= '0;
         out_funct7   <= '0;
         out_rd       <= '0;
         out_rs1_data <= '0;
         out_rs2_data <= '0;
         out_imm      <= '0;
         out_illegal  <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid    <= 1'b1;
         out_pc       <= in_pc;
         out_opcode   <= opcode;
         out_funct3   <= use_f3 ? in_instr[14:12] : 3'b0;
         out_funct7   <= use_f7 ? in_instr[31:25] : 7'b0;
         out_rd       <= dec_rd;
         out_rs1_data <= rs1_data;
         out_rs2_data <= rs2_data;
         out_imm      <= imm_ext;
         out_illegal  <= illegal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
